femto_uart_bus_master: RTL and testbench
========================================

// Module: femto_uart_bus_master
// PURPOSE
// - Debug/loader bus initiator: turns a command byte stream from the UART receiver into
//   word reads/writes on the femtosoc memory bus (same strobe/busy protocol as FemtoRV32).
// - Sits between the UART byte interface and the memory interface; owns the bus only while
//   granted. Responses (ACK/NAK or read data) go back as a byte stream to the UART transmitter.
// PARAMETERS
// - ADDR_WIDTH      24       bus address width; the command carries 3 address bytes
// - TIMEOUT_CYCLES  1000000  idle cycles between command bytes before the parser aborts; 0 disables
// PORTS
// - clk          in   1   system clock (PLL output)
// - reset        in   1   synchronous, active-high
// - rx_data      in   8   received byte
// - rx_valid     in   1   1-cycle pulse: rx_data valid; no backpressure
// - tx_data      out  8   byte to send
// - tx_valid     out  1   held high until accepted
// - tx_ready     in   1   transmitter accepts tx_data when tx_valid && tx_ready
// - bus_req      out  1   request bus ownership
// - bus_gnt      in   1   ownership granted (CPU stalled by arbiter)
// - mem_addr     out  24  word address; bits [1:0] always 0
// - mem_wdata    out  32  write data
// - mem_wmask    out  4   write strobe; nonzero for exactly 1 cycle per write
// - mem_rdata    in   32  read data
// - mem_rstrb    out  1   read strobe; high for exactly 1 cycle per read
// - mem_rbusy    in   1   responder still reading
// - mem_wbusy    in   1   responder still writing
// - overrun      out  1   sticky: a byte arrived while not in IDLE/ADDR/DATA; cleared by reset only
// BEHAVIOUR
// - Reset: state IDLE; tx_valid, bus_req, mem_rstrb, overrun = 0; mem_wmask = 4'b0000;
//   mem_addr, mem_wdata = 0; tx_data = 0; byte counter and timeout counter = 0.
// - Commands: 0x57 'W' + addr[23:16],[15:8],[7:0] (MSB first) + data bytes LSB first -> write
//   wmask 4'b1111, reply 0x06. 0x52 'R' + 3 addr bytes -> read, reply 4 data bytes LSB first.
//   Any other opcode -> reply 0x15, return to IDLE. Address bits [1:0] from the command are dropped.
// - FSM: IDLE -(opcode)-> ADDR (3 bytes) -> DATA ('W' only, 4 bytes) -> REQ -> RSTRB/WSTRB
//   -> RWAIT/WWAIT -> TX -> IDLE.
// - REQ: bus_req=1; stay until bus_gnt. bus_req stays high through RWAIT/WWAIT; drops
//   on entry to TX.
// - RSTRB: mem_rstrb=1 for 1 cycle. RWAIT: capture mem_rdata on the first cycle with
//   mem_rbusy=0; that cycle is earliest 1 cycle after the strobe.
// - WSTRB: mem_wmask=4'b1111 for 1 cycle. WWAIT: leave on the first cycle with mem_wbusy=0.
// - mem_addr/mem_wdata are stable from REQ through the end of the wait state.
// - TX: present bytes one at a time; advance on tx_valid&&tx_ready; tx_data stable while
//   tx_valid. Reply count: 1 for W/NAK, 4 for R. Latency: first reply byte is valid
//   at least 1 cycle after the last command byte + bus wait.
// - Timeout: in ADDR/DATA the counter resets on each rx_valid. At TIMEOUT_CYCLES: back to IDLE,
//   no reply, no bus access.
// - rx_valid in REQ..TX: byte dropped, overrun set; the transaction completes normally.
// - rx_valid and tx handshake in the same cycle: both handled; the byte is still dropped unless in IDLE.
// - bus_gnt deasserted mid-access: does not abort; the arbiter must not revoke before bus_req falls.
// - reset asserted mid-transaction: immediate return to reset values; strobes never extended.
// STRUCTURE
// - Shared package/include femto_bus_master_defs.vh: opcode constants (CMD_WRITE 8'h57,
//   CMD_READ 8'h52, RSP_ACK 8'h06, RSP_NAK 8'h15) and state encodings.
// - One sub-module: femto_cmd_timeout (loadable down-counter, expired flag).
//   The FSM, bus sequencing and TX serializer stay in this module.
// TESTING
// - Write: bytes 57 00 10 04 EF BE AD DE, wbusy=0 -> one cycle wmask=F, addr=0x001004,
//   wdata=0xDEADBEEF; tx byte 0x06.
// - Read with rbusy held 5 cycles after strobe, rdata=0x12345678 -> exactly one rstrb pulse;
//   tx 78 56 34 12.
// - Grant delayed 20 cycles -> no strobe before bus_gnt; bus_req held; bus_req low during TX.
// - Opcode 0x41 -> tx 0x15, no bus_req; next valid 'R' command executes normally.
// - TIMEOUT_CYCLES=16, send 57 00 then silence -> IDLE after 16 cycles, no tx, no bus activity.
// - Byte during TX with tx_ready low 10 cycles -> overrun=1, reply unchanged; reset mid-RWAIT
//   -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/femto_uart_bus_master_pkg.sv
// rtl/femto_uart_bus_master_pkg.sv - opcodes, reply codes and FSM states for the UART bus master
package femto_uart_bus_master_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_REQ,
        S_RSTRB,
        S_WSTRB,
        S_RWAIT,
        S_WWAIT,
        S_TX
    } state_t;

endpackage

// File: rtl/femto_uart_bus_master_cmd_timeout.sv
// rtl/femto_uart_bus_master_cmd_timeout.sv - inter-byte idle down-counter with expired flag
module femto_uart_bus_master_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_load,
    output logic o_expired
);

    logic [31:0] r_count;

    // Reload on every received byte (or while not parsing); count down idle parsing cycles
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= 32'd0;
        end else if (i_load) begin
            r_count <= TIMEOUT_CYCLES;
        end else if (i_run && (r_count != 32'd0)) begin
            r_count <= r_count - 32'd1;
        end
    end

    // A zero budget disables the abort entirely
    assign o_expired = (TIMEOUT_CYCLES != 0) && i_run && !i_load && (r_count == 32'd0);

endmodule

// File: rtl/femto_uart_bus_master.sv
// rtl/femto_uart_bus_master.sv - UART command stream to femtosoc word read/write bus initiator
module femto_uart_bus_master
    import femto_uart_bus_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_bus_req,
    input  logic                  i_bus_gnt,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic [3:0]            o_mem_wmask,
    input  logic [31:0]           i_mem_rdata,
    output logic                  o_mem_rstrb,
    input  logic                  i_mem_rbusy,
    input  logic                  i_mem_wbusy,
    output logic                  o_overrun
);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_is_write;
    logic [15:0] r_addr_hi;
    logic [23:0] r_tx_shift;
    logic [1:0]  r_tx_left;

    logic        w_run;
    logic        w_load;
    logic        w_expired;

    assign w_run  = (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_load = i_rx_valid || !w_run;

    femto_uart_bus_master_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_run     (w_run),
        .i_load    (w_load),
        .o_expired (w_expired)
    );

    // Command parser, bus sequencing and reply serializer with registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_is_write  <= 1'b0;
            r_addr_hi   <= 16'd0;
            r_tx_shift  <= 24'd0;
            r_tx_left   <= 2'd0;
            o_tx_data   <= 8'd0;
            o_tx_valid  <= 1'b0;
            o_bus_req   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= 32'd0;
            o_mem_wmask <= 4'b0000;
            o_mem_rstrb <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            // Bytes arriving while a transaction is in flight are dropped and flagged
            if (i_rx_valid && !(r_state inside {S_IDLE, S_ADDR, S_DATA})) begin
                o_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 2'd0;
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_WRITE) begin
                            r_is_write <= 1'b1;
                            r_state    <= S_ADDR;
                        end else if (i_rx_data == CMD_READ) begin
                            r_is_write <= 1'b0;
                            r_state    <= S_ADDR;
                        end else begin
                            o_tx_data  <= RSP_NAK;
                            o_tx_valid <= 1'b1;
                            r_tx_left  <= 2'd0;
                            r_state    <= S_TX;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_expired) begin
                        r_state <= S_IDLE;
                    end else if (i_rx_valid) begin
                        r_addr_hi <= {r_addr_hi[7:0], i_rx_data};
                        if (r_cnt == 2'd2) begin
                            // Word address: the two byte-offset bits are discarded
                            o_mem_addr <= ADDR_WIDTH'({r_addr_hi, i_rx_data[7:2], 2'b00});
                            r_cnt      <= 2'd0;
                            if (r_is_write) begin
                                r_state <= S_DATA;
                            end else begin
                                o_bus_req <= 1'b1;
                                r_state   <= S_REQ;
                            end
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_expired) begin
                        r_state <= S_IDLE;
                    end else if (i_rx_valid) begin
                        o_mem_wdata <= {i_rx_data, o_mem_wdata[31:8]};
                        if (r_cnt == 2'd3) begin
                            r_cnt     <= 2'd0;
                            o_bus_req <= 1'b1;
                            r_state   <= S_REQ;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                S_REQ: begin
                    if (i_bus_gnt) begin
                        if (r_is_write) begin
                            o_mem_wmask <= 4'b1111;
                            r_state     <= S_WSTRB;
                        end else begin
                            o_mem_rstrb <= 1'b1;
                            r_state     <= S_RSTRB;
                        end
                    end
                end
                S_RSTRB: begin
                    o_mem_rstrb <= 1'b0;
                    r_state     <= S_RWAIT;
                end
                S_WSTRB: begin
                    o_mem_wmask <= 4'b0000;
                    r_state     <= S_WWAIT;
                end
                S_RWAIT: begin
                    if (!i_mem_rbusy) begin
                        o_tx_data  <= i_mem_rdata[7:0];
                        r_tx_shift <= i_mem_rdata[31:8];
                        r_tx_left  <= 2'd3;
                        o_tx_valid <= 1'b1;
                        o_bus_req  <= 1'b0;
                        r_state    <= S_TX;
                    end
                end
                S_WWAIT: begin
                    if (!i_mem_wbusy) begin
                        o_tx_data  <= RSP_ACK;
                        r_tx_left  <= 2'd0;
                        o_tx_valid <= 1'b1;
                        o_bus_req  <= 1'b0;
                        r_state    <= S_TX;
                    end
                end
                S_TX: begin
                    if (o_tx_valid && i_tx_ready) begin
                        if (r_tx_left == 2'd0) begin
                            o_tx_valid <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            o_tx_data  <= r_tx_shift[7:0];
                            r_tx_shift <= {8'd0, r_tx_shift[23:8]};
                            r_tx_left  <= r_tx_left - 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_femto_uart_bus_master.sv
// tb/tb_femto_uart_bus_master.sv - directed self-checking bench for femto_uart_bus_master
module tb_femto_uart_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rstrb;
    logic        mem_rbusy = 1'b0;
    logic        mem_wbusy = 1'b0;
    logic        overrun;

    int n_assert = 0;
    int n_fail   = 0;

    // written only by the monitor
    logic [7:0]  tx_q[$];
    int          rstrb_cnt = 0;
    int          wstrb_cnt = 0;
    int          req_cnt = 0;
    int          req_in_tx = 0;
    int          strobe_no_gnt = 0;
    logic [23:0] seen_raddr = 24'd0;
    logic [23:0] seen_waddr = 24'd0;
    logic [31:0] seen_wdata = 32'd0;
    logic [3:0]  seen_wmask = 4'd0;

    // bench-side snapshots
    int tx_base, r_base, w_base, q_base, tx_bad_base, ng_base, held, stable;

    femto_uart_bus_master #(
        .ADDR_WIDTH     (24),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_bus_req   (bus_req),
        .i_bus_gnt   (bus_gnt),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_wmask (mem_wmask),
        .i_mem_rdata (mem_rdata),
        .o_mem_rstrb (mem_rstrb),
        .i_mem_rbusy (mem_rbusy),
        .i_mem_wbusy (mem_wbusy),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            if (mem_rstrb) begin
                rstrb_cnt  = rstrb_cnt + 1;
                seen_raddr = mem_addr;
                if (!bus_gnt) strobe_no_gnt = strobe_no_gnt + 1;
            end
            if (mem_wmask != 4'd0) begin
                wstrb_cnt  = wstrb_cnt + 1;
                seen_waddr = mem_addr;
                seen_wdata = mem_wdata;
                seen_wmask = mem_wmask;
                if (!bus_gnt) strobe_no_gnt = strobe_no_gnt + 1;
            end
            if (bus_req) req_cnt = req_cnt + 1;
            if (bus_req && tx_valid) req_in_tx = req_in_tx + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic snap();
        tx_base     = tx_q.size();
        r_base      = rstrb_cnt;
        w_base      = wstrb_cnt;
        q_base      = req_cnt;
        tx_bad_base = req_in_tx;
        ng_base     = strobe_no_gnt;
    endtask

    task automatic wait_tx(input string tag, input int n);
        int k = 0;
        while ((tx_q.size() < tx_base + n) && (k < 300)) begin
            tick();
            k++;
        end
        chk(tag, 32'(tx_q.size() >= tx_base + n), 32'd1);
        repeat (3) tick();
    endtask

    task automatic wait_rstrb(input string tag);
        int k = 0;
        while ((rstrb_cnt == r_base) && (k < 100)) begin
            tick();
            k++;
        end
        chk(tag, 32'(rstrb_cnt - r_base), 32'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_txv"},   32'(tx_valid), 32'd0);
        chk({tag, "_txd"},   32'(tx_data), 32'd0);
        chk({tag, "_req"},   32'(bus_req), 32'd0);
        chk({tag, "_rstrb"}, 32'(mem_rstrb), 32'd0);
        chk({tag, "_wmask"}, 32'(mem_wmask), 32'd0);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_ovr"},   32'(overrun), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk_reset_values("reset");
        reset = 1'b0;
        tick();

        // write 0xDEADBEEF to 0x001004
        snap();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h04);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        wait_tx("wr_tx_wait", 1);
        chk("wr_count",  32'(wstrb_cnt - w_base), 32'd1);
        chk("wr_mask",   32'(seen_wmask), 32'hF);
        chk("wr_addr",   32'(seen_waddr), 32'h001004);
        chk("wr_data",   seen_wdata, 32'hDEADBEEF);
        chk("wr_ack",    32'(tx_q[tx_base]), 32'h06);
        chk("wr_ntx",    32'(tx_q.size() - tx_base), 32'd1);
        chk("wr_nrd",    32'(rstrb_cnt - r_base), 32'd0);

        // read with 5 busy cycles after the strobe, low address bits dropped
        snap();
        mem_rbusy = 1'b1;
        mem_rdata = 32'h12345678;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'hAB); send_byte(8'hCF);
        wait_rstrb("rd_strobe");
        repeat (5) tick();
        chk("rd_no_tx_while_busy", 32'(tx_q.size() - tx_base), 32'd0);
        mem_rbusy = 1'b0;
        wait_tx("rd_tx_wait", 4);
        chk("rd_one_strobe", 32'(rstrb_cnt - r_base), 32'd1);
        chk("rd_addr", 32'(seen_raddr), 32'h00ABCC);
        chk("rd_b0", 32'(tx_q[tx_base]),     32'h78);
        chk("rd_b1", 32'(tx_q[tx_base + 1]), 32'h56);
        chk("rd_b2", 32'(tx_q[tx_base + 2]), 32'h34);
        chk("rd_b3", 32'(tx_q[tx_base + 3]), 32'h12);
        chk("rd_ntx", 32'(tx_q.size() - tx_base), 32'd4);

        // grant held off for 20 cycles
        snap();
        bus_gnt = 1'b0;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0B);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        held = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_req) held++;
            tick();
        end
        chk("gnt_req_held", 32'(held), 32'd20);
        chk("gnt_no_strobe", 32'(wstrb_cnt - w_base), 32'd0);
        bus_gnt = 1'b1;
        wait_tx("gnt_tx_wait", 1);
        chk("gnt_wr_count", 32'(wstrb_cnt - w_base), 32'd1);
        chk("gnt_addr", 32'(seen_waddr), 32'h000008);
        chk("gnt_data", seen_wdata, 32'h44332211);
        chk("gnt_strobe_needs_gnt", 32'(strobe_no_gnt - ng_base), 32'd0);
        chk("gnt_req_low_in_tx", 32'(req_in_tx - tx_bad_base), 32'd0);
        chk("gnt_ack", 32'(tx_q[tx_base]), 32'h06);

        // unknown opcode, then a normal read
        snap();
        send_byte(8'h41);
        wait_tx("nak_tx_wait", 1);
        chk("nak_byte", 32'(tx_q[tx_base]), 32'h15);
        chk("nak_no_req", 32'(req_cnt - q_base), 32'd0);
        snap();
        mem_rdata = 32'hCAFEF00D;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        wait_tx("rd2_tx_wait", 4);
        chk("rd2_b0", 32'(tx_q[tx_base]),     32'h0D);
        chk("rd2_b1", 32'(tx_q[tx_base + 1]), 32'hF0);
        chk("rd2_b2", 32'(tx_q[tx_base + 2]), 32'hFE);
        chk("rd2_b3", 32'(tx_q[tx_base + 3]), 32'hCA);
        chk("rd2_addr", 32'(seen_raddr), 32'h000010);

        // gap of 12 idle cycles stays within the budget
        snap();
        mem_rdata = 32'h0BADF00D;
        send_byte(8'h52); send_byte(8'h00);
        repeat (12) tick();
        send_byte(8'h00); send_byte(8'h04);
        wait_tx("gap_tx_wait", 4);
        chk("gap_b3", 32'(tx_q[tx_base + 3]), 32'h0B);

        // silence after a partial command aborts without reply or bus activity
        snap();
        send_byte(8'h57); send_byte(8'h00);
        repeat (40) tick();
        chk("to_no_tx", 32'(tx_q.size() - tx_base), 32'd0);
        chk("to_no_req", 32'(req_cnt - q_base), 32'd0);
        chk("to_no_strobe", 32'((wstrb_cnt - w_base) + (rstrb_cnt - r_base)), 32'd0);
        send_byte(8'h41);
        wait_tx("to_idle_tx_wait", 1);
        chk("to_idle_nak", 32'(tx_q[tx_base]), 32'h15);

        // byte during a stalled reply sets overrun and leaves the reply intact
        chk("ovr_clear_before", 32'(overrun), 32'd0);
        snap();
        tx_ready = 1'b0;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        begin
            int k = 0;
            while (!tx_valid && (k < 100)) begin
                tick();
                k++;
            end
        end
        chk("ovr_txv", 32'(tx_valid), 32'd1);
        send_byte(8'h99);
        stable = 0;
        for (int i = 0; i < 9; i++) begin
            if (tx_valid && (tx_data == 8'h06)) stable++;
            tick();
        end
        chk("ovr_tx_stable", 32'(stable), 32'd9);
        chk("ovr_flag", 32'(overrun), 32'd1);
        tx_ready = 1'b1;
        wait_tx("ovr_tx_wait", 1);
        chk("ovr_ack", 32'(tx_q[tx_base]), 32'h06);
        chk("ovr_ntx", 32'(tx_q.size() - tx_base), 32'd1);
        chk("ovr_wr_count", 32'(wstrb_cnt - w_base), 32'd1);

        // reset in the middle of a read wait
        snap();
        mem_rbusy = 1'b1;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        wait_rstrb("rst_strobe");
        tick();
        chk("rst_req_before", 32'(bus_req), 32'd1);
        reset = 1'b1;
        tick();
        chk_reset_values("rst_mid");
        reset = 1'b0;
        mem_rbusy = 1'b0;
        snap();
        repeat (10) tick();
        chk("rst_no_tx_after", 32'(tx_q.size() - tx_base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
